ms_serial_by2_div: RTL and testbench
====================================

Name: ms_serial_by2_div

Overview:
- MSB-first, radix-2 (one bit per cycle) unsigned restoring divider.
- Inverse-direction companion to ms_serial_by2_mul; same operand-array / en / done interface, so both drop into the same arch-sweep core wrapper and bench.
- Takes dividend and divisor on bin_data_in, produces quotient and remainder DATA_WIDTH cycles after launch.
- Used for multiply/divide round-trip checks in the sweep.

Parameters:
- DATA_WIDTH, 5, width of each operand, of the quotient, and of the remainder.
- NUM_INPUTS, 2, operand array depth. Fixed at 2; elaboration error if any other value.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  start request; sampled only in IDLE or DONE.
- bin_data_in  input  [DATA_WIDTH-1:0] x [NUM_INPUTS-1:0]  element [0] = dividend N, element [1] = divisor D.
- bin_data_out  output  2*DATA_WIDTH  {remainder, quotient}; quotient in [DATA_WIDTH-1:0].
- done  output  1  one-cycle pulse; bin_data_out is valid from this cycle on.
- div_by_zero  output  1  set with done when D==0; held with bin_data_out.

Behaviour:
- Reset (async assert, sync release): state=IDLE; bin_data_out=0; done=0; div_by_zero=0; all internal registers cleared. Reset mid-RUN aborts the operation with no done pulse, and outputs return to 0.
- FSM states IDLE, RUN, DONE:
  - IDLE, en=1 at edge E0: latch N and D into working registers; partial remainder R (DATA_WIDTH+1 bits) = 0; cnt = DATA_WIDTH-1; go to RUN. With en=0, stay in IDLE.
  - RUN, each edge: T = {R[DATA_WIDTH-1:0], Nsh[MSB]}; Nsh <<= 1.
    - If T >= {1'b0,D}: R = T-D and shift 1 into the quotient register.
    - Else: R = T and shift 0 into the quotient register.
    - If cnt==0, go to DONE and register bin_data_out, div_by_zero (= D==0) and done=1. Otherwise cnt--.
  - DONE (exactly one cycle, done=1): with en=1, relaunch exactly as from IDLE (back-to-back, throughput DATA_WIDTH+1 cycles). Otherwise go to IDLE.
- Latency: load edge E0 to done high after edge E_DATA_WIDTH, i.e. DATA_WIDTH cycles.
- done deasserts the cycle after DONE. bin_data_out and div_by_zero hold until the next completion or reset.
- en during RUN is ignored. bin_data_in changes after E0 do not affect the operation in progress.
- Divide by zero: the algorithm is unmodified, giving quotient = all ones and remainder = N; div_by_zero=1.
- Result invariant for D != 0: N = Q*D + R with R < D.
- Subtraction uses a DATA_WIDTH+1-bit compare so the shifted-out MSB is never lost. No other overflow is possible.

Decomposition:
- Package ms_serial_by2_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the counter width function/localparam CNT_W = $clog2(DATA_WIDTH);
  - the operand index localparams IDX_DIVIDEND=0 and IDX_DIVISOR=1, shared with the multiplier.
- Sub-module ms_serial_by2_div_step, purely combinational: inputs R, next dividend bit, D; outputs R_next and q_bit. Instantiated once.

Test Plan (DATA_WIDTH=5):
- N=13, D=3, en pulse -> done exactly 5 cycles after load edge; bin_data_out = {5'd1, 5'd4}; div_by_zero=0.
- N=31, D=1 -> Q=31, R=0. Then N=5, D=9 -> Q=0, R=5.
- N=7, D=0 -> Q=5'b11111, R=7, div_by_zero=1 with done. Next op N=6, D=2 clears it: Q=3, R=0, div_by_zero=0.
- en held high continuously with N=20, D=6, then N=25, D=5 presented in the DONE cycle -> done pulses 6 cycles apart, giving {2,3} then {0,5}. en toggling and bin_data_in changes during RUN have no effect.
- Assert rst 3 cycles into RUN (N=29, D=4) -> outputs 0 immediately (asynchronously), no done. Relaunch after release -> Q=7, R=1.
- Exhaustive sweep of all N, D in 0..31 with a reference model -> N=Q*D+R and R<D for D!=0; D==0 rule as above; done always exactly 5 cycles after launch.

Source files
------------

// File: rtl/ms_serial_by2_pkg.sv
// Shared definitions for the serial radix-2 multiplier/divider pair.
package ms_serial_by2_pkg;

  // Sequencer states common to the serial arithmetic units
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operand positions inside bin_data_in
  localparam int unsigned IDX_DIVIDEND = 0;
  localparam int unsigned IDX_DIVISOR  = 1;

  // Width of a down-counter that must hold width-1
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(5);

endpackage : ms_serial_by2_pkg

// File: rtl/ms_serial_by2_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract divisor.
module ms_serial_by2_div_step #(
  parameter int unsigned DATA_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] r_in,
  input  logic                  n_bit,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] r_next,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] t;

  // Compare at DATA_WIDTH+1 bits so the shifted-out MSB takes part; the
  // difference itself is taken modulo 2^DATA_WIDTH because a kept
  // remainder always fits (R < D, or R == shifted N when D == 0).
  always_comb begin
    t      = {r_in, n_bit};
    q_bit  = (t >= {1'b0, d_in});
    r_next = q_bit ? (t[DATA_WIDTH-1:0] - d_in) : t[DATA_WIDTH-1:0];
  end

endmodule : ms_serial_by2_div_step

// File: rtl/ms_serial_by2_div.sv
// MSB-first radix-2 unsigned restoring divider: {remainder, quotient} after
// DATA_WIDTH cycles, with a divide-by-zero flag.
module ms_serial_by2_div
  import ms_serial_by2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned NUM_INPUTS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   bin_data_in [NUM_INPUTS-1:0],
  output logic [2*DATA_WIDTH-1:0] bin_data_out,
  output logic                    done,
  output logic                    div_by_zero
);

  localparam int unsigned CW = cnt_width(DATA_WIDTH);

  if (NUM_INPUTS != 2) begin : g_bad_num_inputs
    $error("ms_serial_by2_div: NUM_INPUTS must be 2");
  end

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   n_q, n_d;
  logic [DATA_WIDTH-1:0]   d_q, d_d;
  // Only the low DATA_WIDTH bits of the partial remainder are ever carried
  // to the next step; its MSB lives only inside the step's compare.
  logic [DATA_WIDTH-1:0]   r_q, r_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] out_q, out_d;
  logic                    done_q, done_d;
  logic                    dbz_q, dbz_d;

  logic [DATA_WIDTH-1:0]   step_r;
  logic                    step_q;

  ms_serial_by2_div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .r_in  (r_q),
    .n_bit (n_q[DATA_WIDTH-1]),
    .d_in  (d_q),
    .r_next(step_r),
    .q_bit (step_q)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      RUN: begin
        n_d = n_q << 1;
        r_d = step_r;
        q_d = (q_q << 1) | DATA_WIDTH'(step_q);
        if (cnt_q == '0) begin
          state_d = DONE;
          out_d   = {step_r, q_d};
          dbz_d   = (d_q == '0);
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a launch
        if (en) begin
          state_d = RUN;
          n_d     = bin_data_in[IDX_DIVIDEND];
          d_d     = bin_data_in[IDX_DIVISOR];
          r_d     = '0;
          q_d     = '0;
          cnt_d   = CW'(DATA_WIDTH - 1);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bin_data_out = out_q;
  assign done         = done_q;
  assign div_by_zero  = dbz_q;

endmodule : ms_serial_by2_div

// File: tb/tb_ms_serial_by2_div.sv
// Directed-vector bench for ms_serial_by2_div (DATA_WIDTH = 5).
module tb_ms_serial_by2_div;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] bin_data_in [1:0];
  logic [9:0] bin_data_out;
  logic       done;
  logic       div_by_zero;

  int n_cmp;
  int n_err;

  ms_serial_by2_div #(
    .DATA_WIDTH(5),
    .NUM_INPUTS(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bin_data_in (bin_data_in),
    .bin_data_out(bin_data_out),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one operation with an en pulse; returns cycles from load edge to done
  task automatic run_op(input logic [4:0] n, input logic [4:0] d, output int lat);
    bin_data_in[0] = n;
    bin_data_in[1] = d;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    bin_data_in[0] = '0;
    bin_data_in[1] = '0;
    #2;
    n_cmp++;
    if (bin_data_out !== 10'd0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got out=%0h done=%b dbz=%b want out=0 done=0 dbz=0",
               bin_data_out, done, div_by_zero);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_done: got done=%b want 0", done);
    end
  endtask

  task automatic test_basic();
    int lat;
    run_op(5'd13, 5'd3, lat);
    n_cmp++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL basic_latency: got %0d want 5", lat);
    end
    n_cmp++;
    if (bin_data_out !== {5'd1, 5'd4} || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL basic_13_3: got out=%0h dbz=%b want out=%0h dbz=0",
               bin_data_out, div_by_zero, {5'd1, 5'd4});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || bin_data_out !== {5'd1, 5'd4}) begin
      n_err++;
      $display("FAIL done_pulse_hold: got done=%b out=%0h want done=0 out=%0h",
               done, bin_data_out, {5'd1, 5'd4});
    end
  endtask

  task automatic test_boundaries();
    int lat;
    run_op(5'd31, 5'd1, lat);
    n_cmp++;
    if (lat !== 5 || bin_data_out !== {5'd0, 5'd31} || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL div_31_1: got lat=%0d out=%0h dbz=%b want lat=5 out=%0h dbz=0",
               lat, bin_data_out, div_by_zero, {5'd0, 5'd31});
    end
    run_op(5'd5, 5'd9, lat);
    n_cmp++;
    if (lat !== 5 || bin_data_out !== {5'd5, 5'd0} || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL div_5_9: got lat=%0d out=%0h dbz=%b want lat=5 out=%0h dbz=0",
               lat, bin_data_out, div_by_zero, {5'd5, 5'd0});
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(5'd7, 5'd0, lat);
    n_cmp++;
    if (lat !== 5 || bin_data_out !== {5'd7, 5'b11111} || div_by_zero !== 1'b1) begin
      n_err++;
      $display("FAIL div_7_0: got lat=%0d out=%0h dbz=%b want lat=5 out=%0h dbz=1",
               lat, bin_data_out, div_by_zero, {5'd7, 5'b11111});
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (div_by_zero !== 1'b1) begin
      n_err++;
      $display("FAIL dbz_hold: got %b want 1", div_by_zero);
    end
    run_op(5'd6, 5'd2, lat);
    n_cmp++;
    if (lat !== 5 || bin_data_out !== {5'd0, 5'd3} || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL div_6_2: got lat=%0d out=%0h dbz=%b want lat=5 out=%0h dbz=0",
               lat, bin_data_out, div_by_zero, {5'd0, 5'd3});
    end
  endtask

  task automatic test_back_to_back();
    int k1;
    int k2;
    @(posedge clk); #1;
    bin_data_in[0] = 5'd20;
    bin_data_in[1] = 5'd6;
    en = 1'b1;
    @(posedge clk); #1;
    k1 = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        k1 = k;
        break;
      end
    end
    n_cmp++;
    if (k1 !== 5 || bin_data_out !== {5'd2, 5'd3}) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d out=%0h want lat=5 out=%0h",
               k1, bin_data_out, {5'd2, 5'd3});
    end
    // In the DONE cycle: present the next operands with en still high
    bin_data_in[0] = 5'd25;
    bin_data_in[1] = 5'd5;
    k2 = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        en = 1'b0;
        bin_data_in[0] = 5'd31;
        bin_data_in[1] = 5'd2;
      end
      if (k == 3) en = 1'b1;
      if (k == 4) bin_data_in[1] = 5'd0;
      if (done) begin
        k2 = k;
        break;
      end
    end
    en = 1'b0;
    n_cmp++;
    if (k2 !== 6 || bin_data_out !== {5'd0, 5'd5} || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: got gap=%0d out=%0h dbz=%b want gap=6 out=%0h dbz=0",
               k2, bin_data_out, div_by_zero, {5'd0, 5'd5});
    end
    k1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) k1++;
    end
    n_cmp++;
    if (k1 !== 0 || bin_data_out !== {5'd0, 5'd5}) begin
      n_err++;
      $display("FAIL b2b_idle_after: got extra_done=%0d out=%0h want 0 out=%0h",
               k1, bin_data_out, {5'd0, 5'd5});
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    bin_data_in[0] = 5'd29;
    bin_data_in[1] = 5'd4;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bin_data_out !== 10'd0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_run: got out=%0h done=%b dbz=%b want all 0",
               bin_data_out, done, div_by_zero);
    end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL aborted_no_done: got %0d done pulses want 0", seen);
    end
    run_op(5'd29, 5'd4, lat);
    n_cmp++;
    if (lat !== 5 || bin_data_out !== {5'd1, 5'd7} || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL relaunch_29_4: got lat=%0d out=%0h dbz=%b want lat=5 out=%0h dbz=0",
               lat, bin_data_out, div_by_zero, {5'd1, 5'd7});
    end
  endtask

  task automatic test_sweep();
    int lat;
    int q_exp;
    int r_exp;
    int q_got;
    int r_got;
    for (int n = 0; n < 32; n++) begin
      for (int d = 0; d < 32; d++) begin
        run_op(5'(n), 5'(d), lat);
        if (d == 0) begin
          q_exp = 31;
          r_exp = n;
        end else begin
          q_exp = n / d;
          r_exp = n % d;
        end
        q_got = int'(bin_data_out[4:0]);
        r_got = int'(bin_data_out[9:5]);
        n_cmp++;
        if (lat !== 5) begin
          n_err++;
          $display("FAIL sweep_latency n=%0d d=%0d: got %0d want 5", n, d, lat);
        end
        n_cmp++;
        if (q_got !== q_exp || r_got !== r_exp ||
            div_by_zero !== (d == 0) ||
            (d != 0 && (q_got * d + r_got !== n || r_got >= d))) begin
          n_err++;
          $display("FAIL sweep n=%0d d=%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                   n, d, q_got, r_got, div_by_zero, q_exp, r_exp, (d == 0));
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ms_serial_by2_div
